// File: rtl/sonar_rx_frame.sv
// Sonar link receiver: 7O1 UART deserialiser feeding an "AAA,DDD#" frame parser with BCD outputs.
// Optional macro SONAR_RX_PARITY_CHECK_EN turns parity mismatches into character errors.
module sonar_rx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado_rx,
  output logic [3:0]  db_estado_parser,
  output logic [6:0]  db_caractere
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
    S_PARITY = 4'd3,
    S_STOP   = 4'd4
  } rx_state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [6:0] CH_HASH  = 7'h23;
  localparam logic [6:0] CH_COMMA = 7'h2C;

  // ---------------- input synchroniser and bit engine ----------------
  logic            rx_meta_q, rx_sync_q;
  rx_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      shift_q, shift_d;
  logic [6:0]      char_q, char_d;
  logic            char_ok_q, char_ok_d;
  logic            char_err_q, char_err_d;
`ifdef SONAR_RX_PARITY_CHECK_EN
  logic            parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      char_q     <= '0;
      char_ok_q  <= 1'b0;
      char_err_q <= 1'b0;
`ifdef SONAR_RX_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      char_q     <= char_d;
      char_ok_q  <= char_ok_d;
      char_err_q <= char_err_d;
`ifdef SONAR_RX_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    char_d     = char_q;
    char_ok_d  = 1'b0;
    char_err_d = 1'b0;
`ifdef SONAR_RX_PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start sample: a high line here was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[6:1]};
          if (bit_q == 3'd6) state_d = S_PARITY;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_STOP;
`ifdef SONAR_RX_PARITY_CHECK_EN
          parity_err_d = ~(^{shift_q, rx_sync_q});
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          char_d  = shift_q;
`ifdef SONAR_RX_PARITY_CHECK_EN
          if (!rx_sync_q || parity_err_q) char_err_d = 1'b1;
          else                            char_ok_d  = 1'b1;
`else
          if (!rx_sync_q) char_err_d = 1'b1;
          else            char_ok_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    db_estado_rx = state_q;
    db_caractere = char_q;
  end

  // ---------------- frame parser ----------------
  logic [2:0]       idx_q, idx_d;
  logic             sync_q, sync_d;
  logic [5:0][3:0]  dig_q, dig_d;
  logic [11:0]      ang_q, ang_d;
  logic [11:0]      dist_q, dist_d;
  logic             pronto_q, pronto_d;
  logic             erro_q, erro_d;

  logic             is_digit, is_hash, is_comma, expect_ok;
  logic [2:0]       slot;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q    <= '0;
      sync_q   <= 1'b0;
      dig_q    <= '0;
      ang_q    <= '0;
      dist_q   <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      sync_q   <= sync_d;
      dig_q    <= dig_d;
      ang_q    <= ang_d;
      dist_q   <= dist_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    is_digit = (char_q >= 7'h30) && (char_q <= 7'h39);
    is_hash  = (char_q == CH_HASH);
    is_comma = (char_q == CH_COMMA);
    case (idx_q)
      3'd3:    expect_ok = is_comma;
      3'd7:    expect_ok = is_hash;
      default: expect_ok = is_digit;
    endcase
    // Indices 0..2 map to slots 0..2, indices 4..6 to slots 3..5.
    slot = (idx_q < 3'd4) ? idx_q : idx_q - 3'd1;

    idx_d    = idx_q;
    sync_d   = sync_q;
    dig_d    = dig_q;
    ang_d    = ang_q;
    dist_d   = dist_q;
    pronto_d = 1'b0;
    erro_d   = 1'b0;

    if (char_err_q) begin
      erro_d = 1'b1;
      sync_d = 1'b1;
      idx_d  = '0;
      dig_d  = '0;
    end else if (char_ok_q) begin
      if (sync_q) begin
        if (is_hash) begin
          sync_d = 1'b0;
          idx_d  = '0;
        end
      end else if (expect_ok) begin
        if (idx_q == 3'd7) begin
          ang_d    = {dig_q[0], dig_q[1], dig_q[2]};
          dist_d   = {dig_q[3], dig_q[4], dig_q[5]};
          pronto_d = 1'b1;
          idx_d    = '0;
        end else begin
          dig_d[slot] = char_q[3:0];
          idx_d       = idx_q + 1'b1;
        end
      end else begin
        // A stray '#' is itself a frame boundary, so restart without SYNC.
        erro_d = 1'b1;
        dig_d  = '0;
        idx_d  = '0;
        if (!is_hash) sync_d = 1'b1;
      end
    end
  end

  always_comb begin
    angulo           = ang_q;
    distancia        = dist_q;
    pronto           = pronto_q;
    erro             = erro_q;
    db_estado_parser = sync_q ? 4'hF : {1'b0, idx_q};
  end

endmodule

// File: tb/tb_sonar_rx_frame.sv
// Directed bench for sonar_rx_frame with CLKS_PER_BIT=8: table of frames plus hand-written
// back-to-back, glitch and mid-frame reset sequences.
module tb_sonar_rx_frame;

  localparam int CPB = 8;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [11:0] angulo, distancia;
  logic        pronto, erro;
  logic [3:0]  db_estado_rx, db_estado_parser;
  logic [6:0]  db_caractere;

  sonar_rx_frame #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
    .clock            (clk),
    .reset            (reset),
    .rx               (rx),
    .angulo           (angulo),
    .distancia        (distancia),
    .pronto           (pronto),
    .erro             (erro),
    .db_estado_rx     (db_estado_rx),
    .db_estado_parser (db_estado_parser),
    .db_caractere     (db_caractere)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int pronto_cnt = 0;
  int erro_cnt   = 0;
  int both_cnt   = 0;
  logic [11:0] pr_ang  [32];
  logic [11:0] pr_dist [32];

  always @(negedge clk) begin
    if (pronto === 1'b1) begin
      pr_ang[pronto_cnt % 32]  = angulo;
      pr_dist[pronto_cnt % 32] = distancia;
      pronto_cnt++;
    end
    if (erro === 1'b1) erro_cnt++;
    if (pronto === 1'b1 && erro === 1'b1) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Transmit one 7O1 character; called and returns on a falling edge.
  task automatic send_char(input logic [6:0] ch, input logic flip_par, input logic stop_bit);
    logic par;
    par = ~(^ch) ^ flip_par;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx = ch[i];
      repeat (CPB) @(negedge clk);
    end
    rx = par;
    repeat (CPB) @(negedge clk);
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] f, input int flip_idx, input int stop_idx);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c = f[63 - 8*i -: 8];
      send_char(c[6:0], (i == flip_idx), (i != stop_idx));
    end
  endtask

  typedef struct {
    logic [63:0] frame;
    int          flip_idx;
    int          stop_idx;
    int          exp_pronto;
    int          exp_erro;
    logic [11:0] exp_ang;
    logic [11:0] exp_dist;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, e0;

    vecs[0] = '{"090,025#", -1, -1, 1, 0, 12'h090, 12'h025};
    vecs[1] = '{"09X,025#", -1, -1, 0, 1, 12'h090, 12'h025};
    vecs[2] = '{"135,200#", -1, -1, 1, 0, 12'h135, 12'h200};
`ifdef SONAR_RX_PARITY_CHECK_EN
    vecs[3] = '{"090,025#",  2, -1, 0, 1, 12'h135, 12'h200};
    vecs[4] = '{"180,007#", -1,  3, 0, 1, 12'h135, 12'h200};
`else
    vecs[3] = '{"090,025#",  2, -1, 1, 0, 12'h090, 12'h025};
    vecs[4] = '{"180,007#", -1,  3, 0, 1, 12'h090, 12'h025};
`endif
    vecs[5] = '{"180,007#", -1, -1, 1, 0, 12'h180, 12'h007};
    vecs[6] = '{"12#,000#", -1, -1, 0, 2, 12'h180, 12'h007};
    vecs[7] = '{"045,123#", -1, -1, 1, 0, 12'h045, 12'h123};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_angulo",    32'(angulo), 32'h0);
    check("reset_distancia", 32'(distancia), 32'h0);
    check("reset_pronto",    32'(pronto), 32'h0);
    check("reset_erro",      32'(erro), 32'h0);
    check("reset_estado_rx", 32'(db_estado_rx), 32'h0);
    check("reset_parser",    32'(db_estado_parser), 32'h0);
    check("reset_caractere", 32'(db_caractere), 32'h0);

    for (int v = 0; v < 8; v++) begin
      p0 = pronto_cnt;
      e0 = erro_cnt;
      send_frame(vecs[v].frame, vecs[v].flip_idx, vecs[v].stop_idx);
      repeat (20) @(negedge clk);
      $display("vec %0d frame %s flip %0d stop0 %0d: pronto %0d erro %0d angulo %h distancia %h",
               v, vecs[v].frame, vecs[v].flip_idx, vecs[v].stop_idx,
               pronto_cnt - p0, erro_cnt - e0, angulo, distancia);
      check($sformatf("vec%0d_pronto", v), 32'(pronto_cnt - p0), 32'(vecs[v].exp_pronto));
      check($sformatf("vec%0d_erro", v),   32'(erro_cnt - e0),   32'(vecs[v].exp_erro));
      check($sformatf("vec%0d_angulo", v), 32'(angulo),          32'(vecs[v].exp_ang));
      check($sformatf("vec%0d_dist", v),   32'(distancia),       32'(vecs[v].exp_dist));
    end

    // Two frames with no idle gap between them.
    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_frame("045,123#", -1, -1);
    send_frame("180,007#", -1, -1);
    repeat (20) @(negedge clk);
    $display("b2b frames: pronto %0d erro %0d angulo %h distancia %h",
             pronto_cnt - p0, erro_cnt - e0, angulo, distancia);
    check("b2b_pronto",      32'(pronto_cnt - p0), 32'd2);
    check("b2b_erro",        32'(erro_cnt - e0), 32'd0);
    check("b2b_first_ang",   32'(pr_ang[p0 % 32]), 32'h045);
    check("b2b_first_dist",  32'(pr_dist[p0 % 32]), 32'h123);
    check("b2b_angulo",      32'(angulo), 32'h180);
    check("b2b_distancia",   32'(distancia), 32'h007);

    // Short low glitch on an idle line.
    e0 = erro_cnt;
    p0 = pronto_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    $display("glitch: erro %0d pronto %0d estado_rx %0d", erro_cnt - e0, pronto_cnt - p0, db_estado_rx);
    check("glitch_erro",     32'(erro_cnt - e0), 32'd0);
    check("glitch_pronto",   32'(pronto_cnt - p0), 32'd0);
    check("glitch_estado",   32'(db_estado_rx), 32'h0);

    // Reset partway through a frame, then a complete frame.
    send_char(7'h30, 1'b0, 1'b1);
    send_char(7'h34, 1'b0, 1'b1);
    send_char(7'h35, 1'b0, 1'b1);
    send_char(7'h2C, 1'b0, 1'b1);
    send_char(7'h31, 1'b0, 1'b1);
    check("pre_reset_parser", 32'(db_estado_parser), 32'h5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("mid reset: angulo %h distancia %h parser %h caractere %h",
             angulo, distancia, db_estado_parser, db_caractere);
    check("midrst_angulo",    32'(angulo), 32'h0);
    check("midrst_distancia", 32'(distancia), 32'h0);
    check("midrst_parser",    32'(db_estado_parser), 32'h0);
    check("midrst_caractere", 32'(db_caractere), 32'h0);

    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_frame("000,999#", -1, -1);
    repeat (20) @(negedge clk);
    $display("post reset frame: pronto %0d erro %0d angulo %h distancia %h",
             pronto_cnt - p0, erro_cnt - e0, angulo, distancia);
    check("post_pronto",    32'(pronto_cnt - p0), 32'd1);
    check("post_erro",      32'(erro_cnt - e0), 32'd0);
    check("post_angulo",    32'(angulo), 32'h000);
    check("post_distancia", 32'(distancia), 32'h999);
    check("post_caractere", 32'(db_caractere), 32'h23);

    check("pronto_erro_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
